fp_cmp_issuer: RTL and testbench

- Initiator for the fp comparator's act/done interface.
- Accepts compare/min/max requests over a valid/ready handshake and drives operands plus act to the comparator.
- Waits for a qualified done, then returns a predicate bit, a selected value and an invalid flag over a valid/ready result handshake.
- Sits between the FPU decode/issue logic and the comparator, with a timeout watchdog.

---
 rtl/fp_cmp_issuer_pkg.sv | 47 ++++
 rtl/fp_cmp_issuer_resmux.sv | 71 +++++++
 rtl/fp_cmp_issuer.sv | 168 ++++++++++++++++
 tb/tb_fp_cmp_issuer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cmp_issuer_pkg.sv
// ---------------------------------------------------------------------------
// fp_cmp_issuer_pkg
//   Shared definitions for the fp comparator issuer.
//   - Floating-point constant macros (FP_NANS, FP_ZEROP, FP_ZERON, FP_INFP,
//     FP_INFN) and compare op-code macros (CMP_OP_EQ .. CMP_OP_MAX). These are
//     the fp_defs macros. They live in this file so that they are defined once
//     for every file compiled after the package.
//   - Issuer FSM state encodings and typed op-code constants.
// ---------------------------------------------------------------------------
`ifndef FP_DEFS_VH
`define FP_DEFS_VH
`define FP_NANS    32'h7FC00000
`define FP_ZEROP   32'h00000000
`define FP_ZERON   32'h80000000
`define FP_INFP    32'h7F800000
`define FP_INFN    32'hFF800000
`define CMP_OP_EQ  3'd0
`define CMP_OP_LT  3'd1
`define CMP_OP_LE  3'd2
`define CMP_OP_GT  3'd3
`define CMP_OP_GE  3'd4
`define CMP_OP_MIN 3'd5
`define CMP_OP_MAX 3'd6
`endif

package fp_cmp_issuer_pkg;

    // Issuer FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Compare op-codes
    localparam logic [2:0] OP_EQ   = `CMP_OP_EQ;
    localparam logic [2:0] OP_LT   = `CMP_OP_LT;
    localparam logic [2:0] OP_LE   = `CMP_OP_LE;
    localparam logic [2:0] OP_GT   = `CMP_OP_GT;
    localparam logic [2:0] OP_GE   = `CMP_OP_GE;
    localparam logic [2:0] OP_MIN  = `CMP_OP_MIN;
    localparam logic [2:0] OP_MAX  = `CMP_OP_MAX;
    localparam logic [2:0] OP_RSVD = 3'd7;

    // Value returned by MIN/MAX when the comparator flags an invalid compare
    localparam logic [31:0] FP_NAN_S = `FP_NANS;

endpackage

// File: rtl/fp_cmp_issuer_resmux.sv
// ---------------------------------------------------------------------------
// fp_cmp_issuer_resmux
//   Combinational mapping from op-code and comparator flags to the result
//   fields (predicate bit, selected value, invalid flag).
//   Ports:
//     op       in  3  latched op-code
//     a, b     in  W  latched operands
//     eq, great, less, inv  in  1  comparator flags
//     res_bit  out 1  predicate outcome (0 for MIN/MAX)
//     res_val  out W  selected operand for MIN/MAX, else 0
//     res_inv  out 1  invalid compare, bad flag combination or bad op
// ---------------------------------------------------------------------------
module fp_cmp_issuer_resmux
    import fp_cmp_issuer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         eq,
    input  logic         great,
    input  logic         less,
    input  logic         inv,
    output logic         res_bit,
    output logic [W-1:0] res_val,
    output logic         res_inv
);

    localparam logic [W-1:0] NAN_VAL = W'(FP_NAN_S);

    logic [2:0] flags;
    logic       flags_ok;

    assign flags = {eq, great, less};

    // A healthy comparator reports exactly one relation.
    always_comb begin
        flags_ok = 1'b0;
        case (flags)
            3'b001, 3'b010, 3'b100: flags_ok = 1'b1;
            default:                flags_ok = 1'b0;
        endcase
    end

    always_comb begin
        res_bit = 1'b0;
        res_val = '0;
        res_inv = 1'b0;
        if (inv) begin
            res_inv = 1'b1;
            if (op == OP_MIN || op == OP_MAX) begin
                res_val = NAN_VAL;
            end
        end else if (!flags_ok) begin
            res_inv = 1'b1;
        end else begin
            case (op)
                OP_EQ:   res_bit = eq;
                OP_LT:   res_bit = less;
                OP_LE:   res_bit = less | eq;
                OP_GT:   res_bit = great;
                OP_GE:   res_bit = great | eq;
                OP_MIN:  res_val = (less | eq) ? a : b;
                OP_MAX:  res_val = (great | eq) ? a : b;
                default: res_inv = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/fp_cmp_issuer.sv
// ---------------------------------------------------------------------------
// fp_cmp_issuer
//   Initiator for the fp comparator act/done interface. Accepts one
//   compare/min/max request at a time, drives operands and act to the
//   comparator, waits for a qualified done (or a timeout) and returns the
//   result over a result handshake.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. A producer holds valid and its payload until that edge;
//   ready may rise and fall freely and never depends on the same-cycle valid.
//
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     req_valid/req_ready      request handshake
//     req_a, req_b, req_op     request payload
//     cmp_in1, cmp_in2         operands to the comparator (held during act)
//     cmp_act                  comparator activate (ISSUE and WAIT)
//     cmp_eq/great/less/inv    comparator flags, cmp_done completion
//     res_valid/res_ready      result handshake
//     res_bit, res_val         predicate bit, selected value
//     res_inv, res_to          invalid/unsupported flag, timeout flag
//     dbg_state                current FSM state
// ---------------------------------------------------------------------------
module fp_cmp_issuer
    import fp_cmp_issuer_pkg::*;
#(
    parameter int W       = 32,
    parameter int CMP_LAT = 2,
    parameter int TO_CYC  = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [2:0]   req_op,
    output logic [W-1:0] cmp_in1,
    output logic [W-1:0] cmp_in2,
    output logic         cmp_act,
    input  logic         cmp_eq,
    input  logic         cmp_great,
    input  logic         cmp_less,
    input  logic         cmp_done,
    input  logic         cmp_inv,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_bit,
    output logic [W-1:0] res_val,
    output logic         res_inv,
    output logic         res_to,
    output logic [1:0]   dbg_state
);

    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam int LAT_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CMP_LAT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [LAT_W-1:0] lat_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic             lat_done;
    logic             qual_done;
    logic             timeout;
    logic             mux_bit;
    logic [W-1:0]     mux_val;
    logic             mux_inv;

    // Handshake and act outputs are pure state decodes, so a reset edge
    // drops them together with the state.
    assign req_ready = (state == ST_IDLE);
    assign res_valid = (state == ST_RESP);
    assign cmp_act   = (state == ST_ISSUE) || (state == ST_WAIT);
    assign dbg_state = state;

    // done may still be high from the previous op; only trust it once the
    // comparator pipeline has had CMP_LAT cycles to see the new operands.
    assign lat_done  = (lat_cnt >= LAT_LAST);
    assign qual_done = (state == ST_WAIT) && lat_done && cmp_done;
    assign timeout   = (state == ST_WAIT) && !qual_done && (to_cnt == TO_LAST);

    fp_cmp_issuer_resmux #(.W(W)) u_resmux (
        .op      (op_q),
        .a       (cmp_in1),
        .b       (cmp_in2),
        .eq      (cmp_eq),
        .great   (cmp_great),
        .less    (cmp_less),
        .inv     (cmp_inv),
        .res_bit (mux_bit),
        .res_val (mux_val),
        .res_inv (mux_inv)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            cmp_in1 <= '0;
            cmp_in2 <= '0;
            lat_cnt <= '0;
            to_cnt  <= '0;
            res_bit <= 1'b0;
            res_val <= '0;
            res_inv <= 1'b0;
            res_to  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cmp_in1 <= req_a;
                        cmp_in2 <= req_b;
                        op_q    <= req_op;
                        if (req_op == OP_RSVD) begin
                            // Unsupported op: answer immediately, no act.
                            res_bit <= 1'b0;
                            res_val <= '0;
                            res_inv <= 1'b1;
                            res_to  <= 1'b0;
                            state   <= ST_RESP;
                        end else begin
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= '0;
                    to_cnt  <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (qual_done) begin
                        res_bit <= mux_bit;
                        res_val <= mux_val;
                        res_inv <= mux_inv;
                        res_to  <= 1'b0;
                        state   <= ST_RESP;
                    end else if (timeout) begin
                        res_bit <= 1'b0;
                        res_val <= '0;
                        res_inv <= 1'b1;
                        res_to  <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        if (!lat_done) begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_bit <= 1'b0;
                        res_val <= '0;
                        res_inv <= 1'b0;
                        res_to  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_cmp_issuer.sv
module tb_fp_cmp_issuer;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [2:0]   req_op;
    logic [W-1:0] cmp_in1;
    logic [W-1:0] cmp_in2;
    logic         cmp_act;
    logic         cmp_eq;
    logic         cmp_great;
    logic         cmp_less;
    logic         cmp_done;
    logic         cmp_inv;
    logic         res_valid;
    logic         res_ready;
    logic         res_bit;
    logic [W-1:0] res_val;
    logic         res_inv;
    logic         res_to;
    logic [1:0]   dbg_state;

    fp_cmp_issuer #(.W(W), .CMP_LAT(2), .TO_CYC(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .cmp_in1   (cmp_in1),
        .cmp_in2   (cmp_in2),
        .cmp_act   (cmp_act),
        .cmp_eq    (cmp_eq),
        .cmp_great (cmp_great),
        .cmp_less  (cmp_less),
        .cmp_done  (cmp_done),
        .cmp_inv   (cmp_inv),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_bit   (res_bit),
        .res_val   (res_val),
        .res_inv   (res_inv),
        .res_to    (res_to),
        .dbg_state (dbg_state)
    );

    // ---------------- comparator stub ----------------
    // mode 0: done two cycles after act is seen; mode 1: done stuck high;
    // mode 2: done never asserted.
    int   stub_mode;
    logic act_d1;
    logic act_d2;
    int   act_cycles;

    always @(posedge clk) begin
        act_d1 <= cmp_act;
        act_d2 <= act_d1;
        if (cmp_act) act_cycles <= act_cycles + 1;
    end

    assign cmp_done = (stub_mode == 0) ? (cmp_act & act_d2) : (stub_mode == 1);

    // ---------------- scoreboard ----------------
    // entry = {res_bit, res_inv, res_to, res_val}
    logic [W+2:0] exp_q[$];
    int n_checks;
    int n_errors;
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_flags(input logic eq, input logic gt, input logic lt, input logic inv);
        cmp_eq    = eq;
        cmp_great = gt;
        cmp_less  = lt;
        cmp_inv   = inv;
    endtask

    task automatic push_exp(input logic b, input logic inv, input logic to, input logic [W-1:0] v);
        exp_q.push_back({b, inv, to, v});
    endtask

    // Present one request for exactly the accepting cycle (cycle 0).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        @(negedge clk);
        check("req_ready_before_send", req_ready, 1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_valid();
        while (!res_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("res_valid_seen", res_valid, 1);
    endtask

    // Compare the presented result against the head of the expected queue,
    // then complete the result handshake.
    task automatic take_result(input string tag);
        logic [W+2:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_exp_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_bit"}, res_bit, e[W+2]);
            check({tag, "_inv"}, res_inv, e[W+1]);
            check({tag, "_to"},  res_to,  e[W]);
            check({tag, "_val"}, res_val, e[W-1:0]);
        end
        check({tag, "_act_low_in_resp"}, cmp_act, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_valid_cleared"}, res_valid, 0);
        check({tag, "_ready_back"}, req_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int act_before;
        n_checks   = 0;
        n_errors   = 0;
        act_cycles = 0;
        stub_mode  = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        res_ready  = 1'b0;
        set_flags(0, 0, 0, 0);

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_cmp_act",   cmp_act,   0);
        check("rst_cmp_in1",   cmp_in1,   0);
        check("rst_cmp_in2",   cmp_in2,   0);
        check("rst_res_bit",   res_bit,   0);
        check("rst_res_val",   res_val,   0);
        check("rst_res_inv",   res_inv,   0);
        check("rst_res_to",    res_to,    0);
        check("rst_state",     dbg_state, 0);
        rst = 1'b1;

        // LT 1.0 < 2.0, minimum latency
        set_flags(0, 0, 1, 0);
        push_exp(1, 0, 0, 32'h0);
        send(32'h3F800000, 32'h40000000, 3'd1);
        check("lt_issue_act",   cmp_act,   1);
        check("lt_issue_in1",   cmp_in1,   32'h3F800000);
        check("lt_issue_in2",   cmp_in2,   32'h40000000);
        check("lt_issue_ready", req_ready, 0);
        wait_valid();
        check("lt_latency", cyc, 4);
        take_result("lt");

        // MAX(-1.0, 1.0) with result held back for five cycles
        set_flags(0, 0, 1, 0);
        push_exp(0, 0, 0, 32'h3F800000);
        send(32'hBF800000, 32'h3F800000, 3'd6);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("max_hold_valid", res_valid, 1);
            check("max_hold_val",   res_val,   32'h3F800000);
            check("max_hold_ready", req_ready, 0);
        end
        take_result("max");

        // MIN(-1.0, 1.0) selects A
        set_flags(0, 0, 1, 0);
        push_exp(0, 0, 0, 32'hBF800000);
        send(32'hBF800000, 32'h3F800000, 3'd5);
        wait_valid();
        take_result("min");

        // GE with equal operands
        set_flags(1, 0, 0, 0);
        push_exp(1, 0, 0, 32'h0);
        send(32'h40400000, 32'h40400000, 3'd4);
        wait_valid();
        take_result("ge");

        // LE with A greater
        set_flags(0, 1, 0, 0);
        push_exp(0, 0, 0, 32'h0);
        send(32'h40800000, 32'h40400000, 3'd2);
        wait_valid();
        take_result("le");

        // Stale done: done stuck high with stale GT flags; real EQ flags
        // arrive only from the second WAIT cycle on.
        stub_mode = 1;
        set_flags(0, 1, 0, 0);
        push_exp(1, 0, 0, 32'h0);
        send(32'h3F800000, 32'h3F800000, 3'd0);
        @(negedge clk);
        cyc++;
        check("stale_wait_state", dbg_state, 2);
        set_flags(1, 0, 0, 0);
        wait_valid();
        check("stale_latency", cyc, 4);
        take_result("stale");
        stub_mode = 0;

        // Comparator invalid on MIN returns the NaN constant
        set_flags(0, 0, 0, 1);
        push_exp(0, 1, 0, 32'h7FC00000);
        send(32'h7FC00000, 32'h3F800000, 3'd5);
        wait_valid();
        take_result("inv_min");

        // Two relation flags at once is flagged invalid
        set_flags(1, 0, 1, 0);
        push_exp(0, 1, 0, 32'h0);
        send(32'h3F800000, 32'h40000000, 3'd2);
        wait_valid();
        take_result("bad_flags");

        // Timeout: done never comes; 15 WAIT cycles after ISSUE
        stub_mode = 2;
        set_flags(0, 0, 0, 0);
        push_exp(0, 1, 1, 32'h0);
        send(32'h3F800000, 32'h40000000, 3'd0);
        wait_valid();
        check("to_latency", cyc, 17);
        take_result("timeout");
        stub_mode = 0;

        // Reserved op: no act, answer the next cycle
        set_flags(0, 0, 1, 0);
        act_before = act_cycles;
        push_exp(0, 1, 0, 32'h0);
        send(32'h3F800000, 32'h40000000, 3'd7);
        check("rsvd_valid_next", res_valid, 1);
        take_result("rsvd");
        check("rsvd_no_act", act_cycles, act_before);

        // Reset during WAIT discards the request
        stub_mode = 2;
        send(32'h3F800000, 32'h40000000, 3'd1);
        @(negedge clk);
        check("mid_rst_in_wait", dbg_state, 2);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_act",   cmp_act,   0);
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_ready", req_ready, 1);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("mid_rst_no_result", res_valid, 0);
        end
        stub_mode = 0;

        // Clean operation after the mid-flight reset
        set_flags(0, 1, 0, 0);
        push_exp(1, 0, 0, 32'h0);
        send(32'h40000000, 32'h3F800000, 3'd3);
        wait_valid();
        check("post_rst_latency", cyc, 4);
        take_result("post_rst_gt");

        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
